// File: rtl/paint_pkg.sv
// Shared types and constants for the paint path (mouse decoder -> brush
// stamper -> frame-buffer write port).
//   state_t   : stamper FSM states
//   pixel_t   : packed screen coordinate {x, y}
//   PALETTE   : eight RGB332 colours selectable by the middle button
//   H_RES_DEFAULT / V_RES_DEFAULT : default screen size
package paint_pkg;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pixel_t;

  localparam logic [7:0] PALETTE [8] = '{
    8'h00, 8'hE0, 8'h1C, 8'h03, 8'hFC, 8'h1F, 8'hE3, 8'hFF
  };

  localparam int unsigned H_RES_DEFAULT = 640;
  localparam int unsigned V_RES_DEFAULT = 480;

endpackage

// File: rtl/brush_bounds.sv
// Combinational clipped bounding box of a square brush centred on (cx, cy).
// Ports:
//   cx, cy       : brush centre (assumed on-screen)
//   x_lo, x_hi   : clipped column range, inclusive
//   y_lo, y_hi   : clipped row range, inclusive
// Sums are formed at 11 bits so cx+R cannot wrap before the clamp.
module brush_bounds
  import paint_pkg::*;
#(
  parameter int unsigned BRUSH_RADIUS = 2,
  parameter int unsigned H_RES        = H_RES_DEFAULT,
  parameter int unsigned V_RES        = V_RES_DEFAULT
) (
  input  logic [9:0] cx,
  input  logic [9:0] cy,
  output logic [9:0] x_lo,
  output logic [9:0] x_hi,
  output logic [9:0] y_lo,
  output logic [9:0] y_hi
);

  localparam logic [10:0] R     = 11'(BRUSH_RADIUS);
  localparam logic [10:0] X_MAX = 11'(H_RES - 1);
  localparam logic [10:0] Y_MAX = 11'(V_RES - 1);

  logic [10:0] cx_w, cy_w, x_top, y_top;

  always_comb begin
    cx_w  = {1'b0, cx};
    cy_w  = {1'b0, cy};
    x_top = cx_w + R;
    y_top = cy_w + R;
    x_lo  = (cx_w < R) ? '0 : 10'(cx_w - R);
    y_lo  = (cy_w < R) ? '0 : 10'(cy_w - R);
    x_hi  = (x_top > X_MAX) ? 10'(X_MAX) : 10'(x_top);
    y_hi  = (y_top > Y_MAX) ? 10'(Y_MAX) : 10'(y_top);
  end

endmodule

// File: rtl/brush_stamper.sv
// Brush stamper: while a paint button is held, emits one frame-buffer pixel
// write per accepted valid/ready handshake, covering the brush footprint
// centred on the cursor and clipped to the screen.
// Ports:
//   CLOCK_50, RESET_N       : clock, asynchronous active-low reset
//   cursorX, cursorY        : cursor position from the mouse decoder
//   leftButton              : paint with current palette colour
//   middleButton            : rising edge advances the palette index
//   rightButton             : erase (palette entry 0), wins over left
//   wr_valid/wr_ready       : pixel write handshake
//   wr_x, wr_y, wr_color    : pixel write payload (RGB332)
//   color_idx               : current palette index
//   busy                    : stamp in progress
// Optional feature: define BRUSH_ROUND_EN for a round footprint
// (dx*dx + dy*dy <= R*R + R); skipped positions cost one cycle, wr_valid=0.
module brush_stamper
  import paint_pkg::*;
#(
  parameter int unsigned BRUSH_RADIUS = 2,
  parameter int unsigned H_RES        = H_RES_DEFAULT,
  parameter int unsigned V_RES        = V_RES_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [9:0] cursorX,
  input  logic [9:0] cursorY,
  input  logic       leftButton,
  input  logic       middleButton,
  input  logic       rightButton,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [9:0] wr_x,
  output logic [9:0] wr_y,
  output logic [7:0] wr_color,
  output logic [2:0] color_idx,
  output logic       busy
);

  state_t     state_q, state_d;
  pixel_t     pos_q, pos_d;
  pixel_t     center_q, center_d;
  pixel_t     last_q, last_d;
  logic [9:0] x_lo_q, x_lo_d, x_hi_q, x_hi_d, y_lo_q, y_lo_d, y_hi_q, y_hi_d;
  logic [7:0] color_q, color_d;
  logic [2:0] color_idx_q, color_idx_d;
  logic       mid_prev_q, mid_prev_d;
  logic       paint_prev_q, paint_prev_d;
  logic       wr_valid_q, wr_valid_d;
  logic       busy_q, busy_d;

  logic [9:0] b_x_lo, b_x_hi, b_y_lo, b_y_hi;
  logic       paint, trigger, advance;

  brush_bounds #(
    .BRUSH_RADIUS(BRUSH_RADIUS),
    .H_RES       (H_RES),
    .V_RES       (V_RES)
  ) u_bounds (
    .cx  (cursorX),
    .cy  (cursorY),
    .x_lo(b_x_lo),
    .x_hi(b_x_hi),
    .y_lo(b_y_lo),
    .y_hi(b_y_hi)
  );

`ifdef BRUSH_ROUND_EN
  localparam logic [24:0] R_LIMIT = 25'(BRUSH_RADIUS * BRUSH_RADIUS + BRUSH_RADIUS);

  function automatic logic in_brush(input pixel_t p, input pixel_t c);
    logic signed [11:0] dx, dy;
    logic signed [23:0] sq_x, sq_y;
    dx   = $signed({2'b00, p.x}) - $signed({2'b00, c.x});
    dy   = $signed({2'b00, p.y}) - $signed({2'b00, c.y});
    sq_x = dx * dx;
    sq_y = dy * dy;
    return (25'($unsigned(sq_x)) + 25'($unsigned(sq_y))) <= R_LIMIT;
  endfunction
`endif

  always_comb begin
    paint   = leftButton | rightButton;
    trigger = paint && (!paint_prev_q || cursorX != last_q.x || cursorY != last_q.y);
    // A skipped (not emitted) position moves on without waiting for ready.
    advance = wr_ready || !wr_valid_q;

    state_d      = state_q;
    pos_d        = pos_q;
    center_d     = center_q;
    last_d       = last_q;
    x_lo_d       = x_lo_q;
    x_hi_d       = x_hi_q;
    y_lo_d       = y_lo_q;
    y_hi_d       = y_hi_q;
    color_d      = color_q;
    color_idx_d  = color_idx_q;
    mid_prev_d   = middleButton;
    paint_prev_d = paint;

    if (middleButton && !mid_prev_q) begin
      color_idx_d = color_idx_q + 3'd1;
    end

    case (state_q)
      IDLE: begin
        if (trigger) begin
          center_d = '{x: cursorX, y: cursorY};
          x_lo_d   = b_x_lo;
          x_hi_d   = b_x_hi;
          y_lo_d   = b_y_lo;
          y_hi_d   = b_y_hi;
          pos_d    = '{x: b_x_lo, y: b_y_lo};
          color_d  = rightButton ? PALETTE[0] : PALETTE[color_idx_q];
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (advance) begin
          if (pos_q.x == x_hi_q && pos_q.y == y_hi_q) begin
            last_d  = center_q;
            state_d = IDLE;
          end else if (pos_q.x < x_hi_q) begin
            pos_d.x = pos_q.x + 10'd1;
          end else begin
            pos_d.x = x_lo_q;
            pos_d.y = pos_q.y + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered: qualify against the position being loaded.
    busy_d     = (state_d == SCAN);
    wr_valid_d = (state_d == SCAN);
`ifdef BRUSH_ROUND_EN
    if (!in_brush(pos_d, center_d)) begin
      wr_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      pos_q        <= '0;
      center_q     <= '0;
      last_q       <= '0;
      x_lo_q       <= '0;
      x_hi_q       <= '0;
      y_lo_q       <= '0;
      y_hi_q       <= '0;
      color_q      <= '0;
      color_idx_q  <= 3'd1;
      mid_prev_q   <= 1'b0;
      paint_prev_q <= 1'b0;
      wr_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      center_q     <= center_d;
      last_q       <= last_d;
      x_lo_q       <= x_lo_d;
      x_hi_q       <= x_hi_d;
      y_lo_q       <= y_lo_d;
      y_hi_q       <= y_hi_d;
      color_q      <= color_d;
      color_idx_q  <= color_idx_d;
      mid_prev_q   <= mid_prev_d;
      paint_prev_q <= paint_prev_d;
      wr_valid_q   <= wr_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_x      = pos_q.x;
  assign wr_y      = pos_q.y;
  assign wr_color  = color_q;
  assign color_idx = color_idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_brush_stamper.sv
// Directed self-checking bench for brush_stamper (R=2, 640x480).
module tb_brush_stamper;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N;
  logic [9:0] cursorX, cursorY;
  logic       leftButton, middleButton, rightButton;
  logic       wr_valid, wr_ready;
  logic [9:0] wr_x, wr_y;
  logic [7:0] wr_color;
  logic [2:0] color_idx;
  logic       busy;

  int vectors    = 0;
  int miscompares = 0;

  int got_x [64];
  int got_y [64];
  int got_c [64];
  int n_got;

  brush_stamper #(
    .BRUSH_RADIUS(2),
    .H_RES       (640),
    .V_RES       (480)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .cursorX     (cursorX),
    .cursorY     (cursorY),
    .leftButton  (leftButton),
    .middleButton(middleButton),
    .rightButton (rightButton),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_color    (wr_color),
    .color_idx   (color_idx),
    .busy        (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Records accepted writes until busy falls; optionally toggles wr_ready
  // and checks that a stalled payload holds steady.
  task automatic collect(input bit toggle);
    bit         started = 1'b0;
    bit         stall   = 1'b0;
    logic [9:0] sx, sy;
    logic [7:0] sc;
    int         budget;
    n_got = 0;
    for (budget = 0; budget < 200; budget++) begin
      wr_ready = toggle ? ~wr_ready : 1'b1;
      if (stall) begin
        chk("hold_x", wr_x, sx);
        chk("hold_y", wr_y, sy);
        chk("hold_color", wr_color, sc);
        chk("hold_valid", wr_valid, 1);
      end
      if (busy) started = 1'b1;
      if (started && !busy) break;
      stall = wr_valid && !wr_ready;
      sx = wr_x;
      sy = wr_y;
      sc = wr_color;
      if (wr_valid && wr_ready) begin
        if (n_got < 64) begin
          got_x[n_got] = int'(wr_x);
          got_y[n_got] = int'(wr_y);
          got_c[n_got] = int'(wr_color);
        end
        n_got++;
      end
      step();
    end
    if (budget >= 200) chk("collect_timeout", 1, 0);
    wr_ready = 1'b1;
  endtask

  task automatic check_stamp(input string tag, input int cx, input int cy,
                             input int xlo, input int xhi, input int ylo, input int yhi,
                             input logic [7:0] col);
    int n = 0;
    for (int y = ylo; y <= yhi; y++) begin
      for (int x = xlo; x <= xhi; x++) begin
`ifdef BRUSH_ROUND_EN
        if ((x - cx) * (x - cx) + (y - cy) * (y - cy) > 6) continue;
`endif
        if (n < n_got && n < 64) begin
          chk({tag, "_x"}, got_x[n], x);
          chk({tag, "_y"}, got_y[n], y);
          chk({tag, "_color"}, got_c[n], {24'd0, col});
        end
        n++;
      end
    end
    chk({tag, "_count"}, n_got, n);
  endtask

  initial begin
    RESET_N      = 1'b0;
    cursorX      = '0;
    cursorY      = '0;
    leftButton   = 1'b0;
    middleButton = 1'b0;
    rightButton  = 1'b0;
    wr_ready     = 1'b0;
    repeat (2) step();

    chk("rst_valid", wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x", wr_x, 0);
    chk("rst_y", wr_y, 0);
    chk("rst_color", wr_color, 0);
    chk("rst_color_idx", color_idx, 1);
    RESET_N = 1'b1;
    step();

    // Centre stamp
    cursorX = 10'd100; cursorY = 10'd50; leftButton = 1'b1; wr_ready = 1'b1;
    chk("pre_trigger_valid", wr_valid, 0);
    step();
`ifndef BRUSH_ROUND_EN
    chk("latency_valid", wr_valid, 1);
`endif
    chk("latency_busy", busy, 1);
    collect(1'b0);
    check_stamp("centre", 100, 50, 98, 102, 48, 52, 8'hE0);
    chk("centre_end_valid", wr_valid, 0);
    chk("centre_end_busy", busy, 0);

    // Held still: no repeat; then a move restamps
    repeat (5) begin
      step();
      chk("held_no_restamp", busy, 0);
    end
    cursorX = 10'd101;
    step();
    chk("move_busy", busy, 1);
    collect(1'b0);
    check_stamp("move", 101, 50, 99, 103, 48, 52, 8'hE0);
    leftButton = 1'b0;
    step();

    // Palette cycle
    for (int i = 0; i < 8; i++) begin
      middleButton = 1'b1;
      step();
      middleButton = 1'b0;
      step();
      chk("color_cycle", color_idx, (i + 2) % 8);
    end

    // Palette change during a stamp
    cursorX = 10'd200; cursorY = 10'd100; leftButton = 1'b1; wr_ready = 1'b0;
    step();
    chk("scan_pulse_busy", busy, 1);
    middleButton = 1'b1;
    step();
    middleButton = 1'b0;
    step();
    chk("idx_in_scan", color_idx, 2);
    chk("latched_color", wr_color, 8'hE0);
    collect(1'b0);
    check_stamp("scan_pulse", 200, 100, 198, 202, 98, 102, 8'hE0);
    leftButton = 1'b0;
    step();
    leftButton = 1'b1;
    step();
    chk("repress_busy", busy, 1);
    collect(1'b0);
    check_stamp("next_color", 200, 100, 198, 202, 98, 102, 8'h1C);

    // Corner clip with erase
    leftButton = 1'b0;
    step();
    cursorX = 10'd0; cursorY = 10'd479; rightButton = 1'b1;
    step();
    chk("corner_busy", busy, 1);
    collect(1'b0);
    check_stamp("corner", 0, 479, 0, 2, 477, 479, 8'h00);

    // Back-pressure
    rightButton = 1'b0;
    step();
    cursorX = 10'd10; cursorY = 10'd10; leftButton = 1'b1;
    step();
    collect(1'b1);
    check_stamp("backpressure", 10, 10, 8, 12, 8, 12, 8'h1C);

    // Moves during a stamp are ignored until idle
    leftButton = 1'b0;
    step();
    cursorX = 10'd300; cursorY = 10'd200; leftButton = 1'b1; wr_ready = 1'b0;
    step();
    chk("moves_busy", busy, 1);
    cursorX = 10'd310; cursorY = 10'd205;
    step();
    cursorX = 10'd320; cursorY = 10'd210;
    step();
    collect(1'b0);
    check_stamp("first_of_moves", 300, 200, 298, 302, 198, 202, 8'h1C);
    step();
    chk("latest_busy", busy, 1);
    collect(1'b0);
    check_stamp("latest", 320, 210, 318, 322, 208, 212, 8'h1C);
    repeat (4) begin
      step();
      chk("no_extra_stamp", busy, 0);
    end

    // Reset mid-stamp
    leftButton = 1'b0;
    step();
    cursorX = 10'd50; cursorY = 10'd50; leftButton = 1'b1; wr_ready = 1'b1;
    repeat (3) step();
    chk("pre_reset_valid", wr_valid, 1);
    chk("pre_reset_x", wr_x, 50);
    #1 RESET_N = 1'b0;
    #1;
    chk("async_rst_valid", wr_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_x", wr_x, 0);
    chk("async_rst_y", wr_y, 0);
    chk("async_rst_color", wr_color, 0);
    chk("async_rst_idx", color_idx, 1);
    leftButton = 1'b0;
    step();
    RESET_N = 1'b1;
    repeat (4) begin
      step();
      chk("post_reset_idle", wr_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/brush_stamper.md
Name: brush_stamper

Overview:
- Sits directly downstream of the PS/2 mouse decoder.
- Consumes its cursor position (0..639, 0..479) and its three button levels.
- While a paint button is held, emits one pixel write per accepted handshake, covering a square brush footprint centred on the cursor and clipped to the screen.
- Feeds the frame-buffer write port; the frame buffer's write arbiter applies back-pressure through wr_ready.

Parameters:
- BRUSH_RADIUS, 2, half-width of the brush; footprint is (2R+1)x(2R+1) before clipping.
- H_RES, 640, horizontal pixel count; valid x is 0..H_RES-1.
- V_RES, 480, vertical pixel count; valid y is 0..V_RES-1.

Ports:
- CLOCK_50  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- cursorX  in  10  cursor x from mouse decoder.
- cursorY  in  10  cursor y from mouse decoder.
- leftButton  in  1  paint with the current colour.
- middleButton  in  1  rising edge cycles the colour.
- rightButton  in  1  erase (background colour).
- wr_valid  out  1  pixel write request.
- wr_ready  in  1  frame buffer accepts the write.
- wr_x  out  10  pixel x.
- wr_y  out  10  pixel y.
- wr_color  out  8  RGB332 pixel colour.
- color_idx  out  3  current palette index.
- busy  out  1  stamp in progress.

Behaviour:
- Reset values: wr_valid=0, wr_x=0, wr_y=0, wr_color=0, busy=0, color_idx=1. Internally: last stamp position=0, stored button levels=0, state=IDLE.
- Reset mid-stamp aborts immediately; no further writes are issued.
- Colour select:
  - middleButton is registered once; a rising edge (now 1, previous 0) increments color_idx modulo 8 (7 wraps to 0).
  - Edge detection runs in every state.
  - A change during a stamp does not affect that stamp; colour is latched at trigger.
- paint = leftButton | rightButton.
- State IDLE, trigger condition: paint && (previous paint == 0 || cursorX != last_x || cursorY != last_y).
- On trigger:
  - Latch cx, cy.
  - Colour = PALETTE[0] if rightButton, else PALETTE[color_idx]. rightButton wins if both are pressed.
  - Compute clipped bounds:
    - x_lo = (cx < R) ? 0 : cx-R
    - x_hi = (cx+R > H_RES-1) ? H_RES-1 : cx+R
    - y_lo and y_hi likewise against V_RES-1.
  - Bounds use 11-bit arithmetic so cx+R cannot overflow.
  - Go to SCAN with (x,y) = (x_lo,y_lo).
- State SCAN:
  - wr_valid=1 and busy=1; first wr_valid is asserted the cycle after the trigger edge (latency 1).
  - wr_x/wr_y/wr_color are held stable while wr_valid && !wr_ready.
  - On wr_valid && wr_ready: if x < x_hi then x++; else x=x_lo and y++.
  - Scan order is row-major, x inner.
  - The write accepted at (x_hi,y_hi) ends the stamp: store last_x=cx, last_y=cy, go to IDLE; wr_valid drops the next cycle.
- Button release or cursor movement during SCAN does not abort; the stamp completes. Moves are re-evaluated only in IDLE, so intermediate positions may be skipped.
- Cursor held still with the button held: exactly one stamp, no repeats.
- Throughput: one pixel per cycle while wr_ready is held high. Unclipped R=2 gives 25 writes; IDLE always lasts at least one cycle between stamps.

Optional Feature:
- Macro BRUSH_ROUND_EN.
- When defined, the footprint is round: a pixel with offset dx=x-cx, dy=y-cy is emitted only if dx*dx+dy*dy <= R*R+R.
- Skipped positions advance the scan in one cycle with wr_valid=0.
- For R=2 the four corners are dropped, giving 21 writes unclipped.
- When not defined, the full square is emitted and no multiplier logic exists.

Decomposition:
- Package paint_pkg holds:
  - typedef for the state enum {IDLE, SCAN};
  - typedef for a pixel coordinate struct {x[9:0], y[9:0]};
  - constant PALETTE[8] of RGB332: 00, E0, 1C, 03, FC, 1F, E3, FF;
  - constants H_RES_DEFAULT and V_RES_DEFAULT.
- One natural sub-module: brush_bounds. It is combinational and produces x_lo/x_hi/y_lo/y_hi from cx, cy, R, H_RES and V_RES; it is reused by a future preview-cursor overlay.

Test Plan:
- Centre stamp: reset, cursor (100,50), leftButton 0->1, wr_ready=1 -> wr_valid the next cycle; 25 writes (98..102, 48..52) in row-major order, colour E0; busy drops after the 25th.
- Corner clip: cursor (0,479), rightButton held -> 9 writes, x 0..2, y 477..479, colour 00.
- Back-pressure: stamp at (10,10) with wr_ready toggling 1/0 each cycle -> outputs stable while ready is low; 25 distinct writes, none duplicated.
- Colour cycle: eight middleButton pulses from reset -> color_idx 1,2,..7,0,1. Pulse during SCAN -> the current stamp keeps its latched colour and the next stamp uses the new one.
- Held button, no move -> exactly one stamp. Then move to (101,50) -> a second stamp starts. Move during SCAN -> ignored until IDLE, then one stamp at the latest position.
- RESET_N low mid-SCAN -> wr_valid, busy and wr_* go to 0 asynchronously. With BRUSH_ROUND_EN defined, the centre stamp yields 21 writes and excludes (98,48), (102,48), (98,52) and (102,52).
